// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: tag/data widths, the idle tag and the broadcast entry layout.
// Reservation stations and the ROB import the same package.
package cdb_pkg;
    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;
    localparam logic [TAG_W-1:0] INVALID_TAG = 6'b010000;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;
endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result buffer: DEPTH entries, wrapping pointers, count one bit wider.
// The caller never pushes when full nor pops when empty.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 38
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [PTR_W:0]   count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Storage carries no reset; stale words are unreachable once count is cleared.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wptr] <= din;
    end

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];
endmodule

// File: rtl/cdb_arbiter.sv
// Collects finished results from NUM_SRC units and broadcasts up to two per cycle
// on CDB0/CDB1 using a two-stage round-robin scan from rr.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic                        cdb0_valid,
    output logic [TAG_W-1:0]            cdb0_tag,
    output logic [DATA_W-1:0]           cdb0_data,
    output logic                        cdb1_valid,
    output logic [TAG_W-1:0]            cdb1_tag,
    output logic [DATA_W-1:0]           cdb1_data
);
    import cdb_pkg::*;

    localparam int IDX_W = $clog2(NUM_SRC);
    localparam int EW    = TAG_W + DATA_W;
    localparam logic [TAG_W-1:0] IDLE_TAG = TAG_W'(INVALID_TAG);

    logic [NUM_SRC-1:0]         full, empty, push, pop;
    logic [NUM_SRC-1:0][EW-1:0] head;
    logic [IDX_W-1:0]           rr, rr_nxt, g0, g1;
    logic                       hit0, hit1;
    logic [IDX_W:0]             scan;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] g);
        return (int'(g) == NUM_SRC-1) ? '0 : g + 1'b1;
    endfunction

    // Tags at or above INVALID_TAG never enter the buffer.
    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_src
            assign push[i] = src_valid[i] & ~full[i] & ~flush
                           & (src_tag[i*TAG_W +: TAG_W] < IDLE_TAG);
            result_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
                .clock (clock),
                .reset (reset),
                .flush (flush),
                .push  (push[i]),
                .pop   (pop[i]),
                .din   ({src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]}),
                .full  (full[i]),
                .empty (empty[i]),
                .head  (head[i])
            );
        end
    endgenerate

    assign src_ready = ~full;

    // First non-empty from rr goes to CDB0, the next one along the same scan to CDB1.
    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        g0   = '0;
        g1   = '0;
        scan = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan = {1'b0, rr} + (IDX_W+1)'(k);
            if (int'(scan) >= NUM_SRC) scan = scan - (IDX_W+1)'(NUM_SRC);
            if (!empty[scan[IDX_W-1:0]]) begin
                if (!hit0) begin
                    hit0 = 1'b1;
                    g0   = scan[IDX_W-1:0];
                end else if (!hit1) begin
                    hit1 = 1'b1;
                    g1   = scan[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        if (hit0) pop[g0] = 1'b1;
        if (hit1) pop[g1] = 1'b1;
        rr_nxt = rr;
        if (hit1)      rr_nxt = next_idx(g1);
        else if (hit0) rr_nxt = next_idx(g0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr         <= '0;
            cdb0_valid <= 1'b0;
            cdb0_tag   <= IDLE_TAG;
            cdb0_data  <= '0;
            cdb1_valid <= 1'b0;
            cdb1_tag   <= IDLE_TAG;
            cdb1_data  <= '0;
        end else if (flush) begin
            rr         <= '0;
            cdb0_valid <= 1'b0;
            cdb0_tag   <= IDLE_TAG;
            cdb0_data  <= '0;
            cdb1_valid <= 1'b0;
            cdb1_tag   <= IDLE_TAG;
            cdb1_data  <= '0;
        end else begin
            rr         <= rr_nxt;
            cdb0_valid <= hit0;
            cdb0_tag   <= hit0 ? head[g0][EW-1 -: TAG_W] : IDLE_TAG;
            cdb0_data  <= hit0 ? head[g0][DATA_W-1:0] : '0;
            cdb1_valid <= hit1;
            cdb1_tag   <= hit1 ? head[g1][EW-1 -: TAG_W] : IDLE_TAG;
            cdb1_data  <= hit1 ? head[g1][DATA_W-1:0] : '0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded bench for cdb_arbiter: a queue-based reference model predicts each
// cycle's broadcasts and readies; a negedge monitor pops and compares.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int TW = 6;
    localparam int DW = 32;

    logic              clock, reset, flush;
    logic [N-1:0]      src_valid;
    logic [N*TW-1:0]   src_tag;
    logic [N*DW-1:0]   src_data;
    logic [N-1:0]      src_ready;
    logic              cdb0_valid, cdb1_valid;
    logic [TW-1:0]     cdb0_tag, cdb1_tag;
    logic [DW-1:0]     cdb0_data, cdb1_data;

    cdb_arbiter #(.NUM_SRC(N), .DEPTH(D), .TAG_W(TW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_ready(src_ready),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data)
    );

    typedef struct {
        logic          v0;
        logic [TW-1:0] t0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [TW-1:0] t1;
        logic [DW-1:0] d1;
        logic [N-1:0]  rdy;
    } exp_t;

    cdb_entry_t q[N][$];
    exp_t       exp_q[$];
    int         rr = 0;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t idle_exp();
        exp_t e;
        e.v0 = 1'b0; e.t0 = INVALID_TAG; e.d0 = '0;
        e.v1 = 1'b0; e.t1 = INVALID_TAG; e.d1 = '0;
        e.rdy = '1;
        return e;
    endfunction

    // Reference: pop the winners of the pre-edge scan, then accept pushes that saw room.
    task automatic model_step();
        exp_t         e;
        cdb_entry_t   x;
        logic [N-1:0] room;
        int           g0, g1, s;
        e = idle_exp();
        if (reset || flush) begin
            for (int i = 0; i < N; i++) q[i].delete();
            rr = 0;
        end else begin
            for (int i = 0; i < N; i++) room[i] = (q[i].size() < D);
            g0 = -1; g1 = -1;
            for (int k = 0; k < N; k++) begin
                s = (rr + k) % N;
                if (q[s].size() > 0) begin
                    if (g0 < 0) g0 = s;
                    else if (g1 < 0) g1 = s;
                end
            end
            if (g0 >= 0) begin
                x = q[g0].pop_front();
                e.v0 = 1'b1; e.t0 = x.tag; e.d0 = x.data;
                rr = (g0 + 1) % N;
            end
            if (g1 >= 0) begin
                x = q[g1].pop_front();
                e.v1 = 1'b1; e.t1 = x.tag; e.d1 = x.data;
                rr = (g1 + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && room[i] && src_tag[i*TW +: TW] < 16) begin
                    x.tag  = src_tag[i*TW +: TW];
                    x.data = src_data[i*DW +: DW];
                    q[i].push_back(x);
                end
            end
        end
        for (int i = 0; i < N; i++) e.rdy[i] = (q[i].size() < D);
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Monitor
    initial forever begin
        exp_t e;
        @(negedge clock);
        cyc++;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty cyc=%0d: no expectation queued", cyc);
        end else begin
            e = exp_q.pop_front();
            if (reset) e = idle_exp();
            if (cdb0_valid !== e.v0 || cdb0_tag !== e.t0 || cdb0_data !== e.d0 ||
                cdb1_valid !== e.v1 || cdb1_tag !== e.t1 || cdb1_data !== e.d1 ||
                src_ready !== e.rdy) begin
                failures++;
                $display("FAIL cdb cyc=%0d got %b/%0d/%h %b/%0d/%h rdy=%b expected %b/%0d/%h %b/%0d/%h rdy=%b",
                         cyc, cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data, src_ready,
                         e.v0, e.t0, e.d0, e.v1, e.t1, e.d1, e.rdy);
            end
        end
    end

    function automatic logic [N*TW-1:0] tags(input int a, input int b, input int c, input int d);
        logic [N*TW-1:0] t;
        t = {TW'(d), TW'(c), TW'(b), TW'(a)};
        return t;
    endfunction

    function automatic logic [N*DW-1:0] datas(input int a, input int b, input int c, input int d);
        logic [N*DW-1:0] t;
        t = {DW'(d), DW'(c), DW'(b), DW'(a)};
        return t;
    endfunction

    // Called at posedge+1; holds inputs through the next edge.
    task automatic drive(input logic [N-1:0] v, input logic [N*TW-1:0] t,
                         input logic [N*DW-1:0] d, input logic f);
        src_valid = v; src_tag = t; src_data = d; flush = f;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, '0, '0, 1'b0);
    endtask

    task automatic async_reset_check();
        src_valid = '0; flush = 1'b0;
        reset = 1'b1;
        #2;
        checks++;
        if (src_ready !== '1 || cdb0_valid !== 1'b0 || cdb1_valid !== 1'b0 ||
            cdb0_tag !== INVALID_TAG || cdb1_tag !== INVALID_TAG ||
            cdb0_data !== '0 || cdb1_data !== '0) begin
            failures++;
            $display("FAIL async_reset got rdy=%b v=%b%b t=%0d/%0d d=%h/%h expected rdy=1111 v=00 t=16/16 d=0/0",
                     src_ready, cdb0_valid, cdb1_valid, cdb0_tag, cdb1_tag, cdb0_data, cdb1_data);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        src_valid = '0; src_tag = '0; src_data = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // single result on source 2
        drive(4'b0100, tags(0, 0, 5, 0), datas(0, 0, 1, 0), 1'b0);
        idle(2);
        // dual grant and rotation
        drive(4'b1011, tags(1, 2, 0, 3), datas(32'h11, 32'h22, 0, 32'h33), 1'b0);
        idle(3);
        // flood: source 0 tags 8..12, others busy too
        for (int k = 0; k < 5; k++)
            drive(4'b1111, tags(8 + k, k, 4 + k, 13), datas(100 + k, 200 + k, 300 + k, 400 + k), 1'b0);
        idle(10);
        // load then flush
        for (int k = 0; k < 3; k++)
            drive(4'b1111, tags(k, 3 + k, 6 + k, 9 + k), datas(k, k + 1, k + 2, k + 3), 1'b0);
        drive(4'b1111, tags(7, 7, 7, 7), datas(7, 7, 7, 7), 1'b1);
        idle(4);
        // invalid tag on source 1
        drive(4'b0010, tags(0, 16, 0, 0), datas(0, 32'hdead, 0, 0), 1'b0);
        idle(2);
        // async reset while traffic is buffered
        drive(4'b1111, tags(1, 2, 3, 4), datas(1, 2, 3, 4), 1'b0);
        async_reset_check();
        idle(2);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0]    v;
            logic [N*TW-1:0] t;
            logic [N*DW-1:0] d;
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 99) < 55);
                t[i*TW +: TW] = TW'($urandom_range(0, 19));
                d[i*DW +: DW] = $urandom;
            end
            if (c == 300) async_reset_check();
            else drive(v, t, d, $urandom_range(0, 39) == 0);
        end
        idle(12);

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
